// File: rtl/sm_step_ctrl.sv
// rtl/sm_step_ctrl.sv - run/halt/single-step clock-enable sequencer for the schoolRISCV core
// Optional cycle breakpoint enabled by defining SM_STEP_BRK_EN.
module sm_step_ctrl #(
    parameter int DEBOUNCE_W = 16,
    parameter int DIV_W      = 4
) (
    input  logic             clkIn,
    input  logic             rst_n,
    input  logic             runMode,
    input  logic             stepBtn_n,
    input  logic [DIV_W-1:0] clkDivide,
    input  logic             brkEn,
    input  logic [31:0]      brkCount,
    output logic             clkEnable,
    output logic             halted,
    output logic [1:0]       state,
    output logic [31:0]      cycleCount
);

    localparam int PW = 1 << DIV_W;

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_BRK  = 2'b11
    } state_t;

    state_t                cur;
    state_t                nxt;
    logic                  run_meta, run_s;
    logic                  btn_meta, btn_s;
    logic                  debounced;
    logic [DEBOUNCE_W-1:0] db_cnt;
    logic                  step_set;
    logic                  step_req;
    logic [PW-1:0]         pcnt;
    logic [PW-1:0]         limit;
    logic                  tick;
    logic                  pulse;
    logic                  clr_req;
    logic                  brk_hit;

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            run_meta <= 1'b0;
            run_s    <= 1'b0;
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            run_meta <= runMode;
            run_s    <= run_meta;
            btn_meta <= stepBtn_n;
            btn_s    <= btn_meta;
        end
    end

    // A step request is raised only when a debounced press (1->0) is accepted.
    assign step_set = (btn_s != debounced) && (&db_cnt) && debounced && !btn_s;

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            debounced <= 1'b1;
            db_cnt    <= '0;
        end else if (btn_s != debounced) begin
            if (&db_cnt) begin
                debounced <= btn_s;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // >= compare so a lowered clkDivide mid-count ticks immediately instead of wrapping.
    assign limit = (PW'(1) << clkDivide) - PW'(1);
    assign tick  = (pcnt >= limit);

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n)    pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 1'b1;
    end

`ifdef SM_STEP_BRK_EN
    assign brk_hit = brkEn && ((cycleCount + 32'd1) == brkCount);
`else
    logic unused_brk;
    assign unused_brk = ^{brkEn, brkCount};
    assign brk_hit    = 1'b0;
`endif

    always_comb begin
        nxt     = cur;
        clr_req = 1'b0;
        pulse   = 1'b0;
        case (cur)
            S_HALT: begin
                if (run_s) begin
                    nxt     = S_RUN;
                    clr_req = 1'b1;
                end else if (step_req) begin
                    nxt = S_STEP;
                end
            end
            S_RUN: begin
                clr_req = 1'b1;
                if (!run_s) begin
                    nxt = S_HALT;
                end else if (tick) begin
                    pulse = 1'b1;
                    if (brk_hit) nxt = S_BRK;
                end
            end
            S_STEP: begin
                if (tick) begin
                    pulse   = 1'b1;
                    nxt     = S_HALT;
                    clr_req = 1'b1;
                end
            end
            S_BRK: begin
                clr_req = 1'b1;
                if (!run_s) nxt = S_HALT;
            end
            default: nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= S_HALT;
            clkEnable  <= 1'b0;
            halted     <= 1'b1;
            cycleCount <= '0;
            step_req   <= 1'b0;
        end else begin
            cur       <= nxt;
            clkEnable <= pulse;
            halted    <= (nxt == S_HALT) || (nxt == S_BRK);
            if (pulse) cycleCount <= cycleCount + 32'd1;
            if (clr_req)       step_req <= 1'b0;
            else if (step_set) step_req <= 1'b1;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_sm_step_ctrl.sv
// tb/tb_sm_step_ctrl.sv - directed scoreboard bench for sm_step_ctrl
module tb_sm_step_ctrl;

    logic        clkIn     = 1'b0;
    logic        rst_n     = 1'b0;
    logic        runMode   = 1'b0;
    logic        stepBtn_n = 1'b1;
    logic [3:0]  clkDivide = 4'd0;
    logic        brkEn     = 1'b0;
    logic [31:0] brkCount  = 32'd0;
    logic        clkEnable;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] cycleCount;

    sm_step_ctrl #(.DEBOUNCE_W(3), .DIV_W(4)) dut (
        .clkIn      (clkIn),
        .rst_n      (rst_n),
        .runMode    (runMode),
        .stepBtn_n  (stepBtn_n),
        .clkDivide  (clkDivide),
        .brkEn      (brkEn),
        .brkCount   (brkCount),
        .clkEnable  (clkEnable),
        .halted     (halted),
        .state      (state),
        .cycleCount (cycleCount)
    );

    always #5 clkIn = ~clkIn;

    int          compared    = 0;
    int          mismatched  = 0;
    int          pulse_total = 0;
    int          pulse_ref   = 0;
    int          p0;
    bit          sb_en       = 1'b0;
    logic [31:0] sb_q[$];
    logic [31:0] base        = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_count();
        return base + 32'(pulse_total - pulse_ref);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clkIn);
        #1;
    endtask

    task automatic press(input int low);
        stepBtn_n = 1'b0;
        cyc(low);
        stepBtn_n = 1'b1;
        cyc(20);
    endtask

    always @(negedge clkIn) begin
        if (rst_n && clkEnable) begin
            pulse_total++;
            if (sb_en) begin
                if (sb_q.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
                else                  check("sb_cycle_count", cycleCount, sb_q.pop_front());
            end
        end
    end

    initial begin
        cyc(3);
        rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 50; i++)
            check("idle_outputs", {28'd0, clkEnable, halted, state}, 32'b0100);
        check("idle_count", cycleCount, 32'd0);

        // free run at divide-by-4
        for (int i = 1; i <= 10; i++) sb_q.push_back(32'(i));
        sb_en     = 1'b1;
        clkDivide = 4'd2;
        runMode   = 1'b1;
        cyc(3);
        check("run_state", {30'd0, state}, 32'd1);
        check("run_halted", {31'd0, halted}, 32'd0);
        cyc(40);
        sb_en = 1'b0;
        check("run_sb_drained", 32'(sb_q.size()), 32'd0);
        check("run_count_40", cycleCount, 32'd10);

        // run -> halt
        p0      = pulse_total;
        runMode = 1'b0;
        cyc(10);
        check("fall_pulses_le3", {31'd0, (pulse_total - p0) <= 3}, 32'd1);
        check("fall_state", {30'd0, state}, 32'd0);
        check("fall_halted", {31'd0, halted}, 32'd1);
        check("fall_count", cycleCount, model_count());

        // single step
        clkDivide = 4'd0;
        sb_q.push_back(model_count() + 32'd1);
        sb_en = 1'b1;
        press(20);
        check("step_sb_drained", 32'(sb_q.size()), 32'd0);
        check("step_state", {30'd0, state}, 32'd0);
        check("step_halted", {31'd0, halted}, 32'd1);

        // short glitch: no pulse expected (monitor flags any)
        p0 = pulse_total;
        press(3);
        check("glitch_pulses", 32'(pulse_total - p0), 32'd0);
        check("glitch_state", {30'd0, state}, 32'd0);

        // counter wrap via two steps
        force dut.cycleCount = 32'hFFFF_FFFE;
        #1;
        release dut.cycleCount;
        base      = 32'hFFFF_FFFE;
        pulse_ref = pulse_total;
        check("force_count", cycleCount, 32'hFFFF_FFFE);
        sb_q.push_back(32'hFFFF_FFFF);
        press(20);
        check("wrap_step1", cycleCount, 32'hFFFF_FFFF);
        sb_q.push_back(32'h0000_0000);
        press(20);
        check("wrap_step2", cycleCount, 32'h0000_0000);
        check("wrap_sb_drained", 32'(sb_q.size()), 32'd0);
        sb_en = 1'b0;

        // reset in the middle of RUN
        runMode = 1'b1;
        cyc(10);
        check("rerun_state", {30'd0, state}, 32'd1);
        brkEn    = 1'b1;
        brkCount = 32'd5;
        rst_n    = 1'b0;
        #1;
        check("rst_outputs", {28'd0, clkEnable, halted, state}, 32'b0100);
        check("rst_count", cycleCount, 32'd0);
        cyc(3);
        base      = 32'd0;
        pulse_ref = pulse_total;
        clkDivide = 4'd1;

`ifdef SM_STEP_BRK_EN
        for (int i = 1; i <= 5; i++) sb_q.push_back(32'(i));
        sb_en = 1'b1;
        rst_n = 1'b1;
        cyc(60);
        sb_en = 1'b0;
        check("brk_sb_drained", 32'(sb_q.size()), 32'd0);
        check("brk_state", {30'd0, state}, 32'd3);
        check("brk_halted", {31'd0, halted}, 32'd1);
        check("brk_count", cycleCount, 32'd5);
        runMode = 1'b0;
        cyc(5);
        check("brk_exit_state", {30'd0, state}, 32'd0);
        check("brk_exit_halted", {31'd0, halted}, 32'd1);
`else
        rst_n = 1'b1;
        cyc(60);
        check("nobrk_state", {30'd0, state}, 32'd1);
        check("nobrk_halted", {31'd0, halted}, 32'd0);
        check("nobrk_past5", {31'd0, cycleCount > 32'd5}, 32'd1);
        check("nobrk_count", cycleCount, model_count());
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
